// File: rtl/mult16_share_arbiter.sv
// Two-requester arbiter feeding one shared 16x16 signed radix-4 Booth multiplier.
// Two-stage pipeline: S1 holds the accepted operands, S2 holds the registered product.
module mult16_share_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [31:0] out_p,
    output logic        out_id,
    input  logic        out_ready,
    output logic        busy
);
    localparam int unsigned OP_W = 16;
    localparam int unsigned PP_W = OP_W + 1;
    localparam int unsigned P_W  = 2 * OP_W;
    localparam int unsigned NPP  = OP_W / 2;
    localparam logic        RR   = (RR_EN != 0);

    logic            s1_valid;
    logic [OP_W-1:0] s1_a;
    logic [OP_W-1:0] s1_b;
    logic            s1_id;
    logic            rr_ptr;

    logic stall, s1_load;
    logic grant0, grant1, xfer0, xfer1, xfer_any;

    // Arbitration and flow control
    assign stall    = out_valid & ~out_ready;
    assign s1_load  = ~s1_valid | ~stall;
    assign grant1   = req1_valid & (~req0_valid | (RR & rr_ptr));
    assign grant0   = req0_valid & ~grant1;
    assign req0_ready = grant0 & s1_load & ~sys_rst;
    assign req1_ready = grant1 & s1_load & ~sys_rst;
    assign xfer0    = req0_valid & req0_ready;
    assign xfer1    = req1_valid & req1_ready;
    assign xfer_any = xfer0 | xfer1;
    assign busy     = s1_valid | out_valid;

    // Carry-save 3:2 compressor on full-width rows; carry row is pre-shifted
    function automatic logic [2*P_W-1:0] csa(input logic [P_W-1:0] x,
                                             input logic [P_W-1:0] y,
                                             input logic [P_W-1:0] z);
        logic [P_W-1:0] s;
        logic [P_W-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    logic [OP_W:0]   b_ext;
    logic [PP_W-1:0] a_x1, a_x2;
    logic [NPP-1:0]  pp_neg;
    logic [P_W-1:0]  pp_row [NPP+1];
    logic [P_W-1:0]  neg_row;

    assign b_ext = {s1_b, 1'b0};
    assign a_x1  = {s1_a[OP_W-1], s1_a};
    assign a_x2  = {s1_a, 1'b0};

    // Booth rows are one's-complemented when negative; the +1 goes in neg_row
    for (genvar i = 0; i < NPP; i++) begin : g_booth
        logic [2:0]      sel;
        logic [PP_W-1:0] mag;
        logic [PP_W-1:0] pp;
        logic            neg;

        assign sel = b_ext[2*i+2 -: 3];

        always_comb begin
            mag = '0;
            neg = 1'b0;
            case (sel)
                3'b001, 3'b010: mag = a_x1;
                3'b011:         mag = a_x2;
                3'b100:         begin mag = a_x2; neg = 1'b1; end
                3'b101, 3'b110: begin mag = a_x1; neg = 1'b1; end
                default:        mag = '0;
            endcase
        end

        assign pp        = mag ^ {PP_W{neg}};
        assign pp_neg[i] = neg;
        assign pp_row[i] = {{(P_W-PP_W){pp[PP_W-1]}}, pp} << (2*i);
    end

    always_comb begin
        neg_row = '0;
        for (int k = 0; k < NPP; k++) begin
            neg_row[2*k] = pp_neg[k];
        end
    end
    assign pp_row[NPP] = neg_row;

    // Nine rows reduced to two: 9 -> 6 -> 4 -> 3 -> 2
    logic [P_W-1:0] s0, c0, s1, c1, s2, c2;
    logic [P_W-1:0] t0, d0, t1, d1, u0, e0, v0, f0;
    logic [P_W-1:0] product;

    assign {c0, s0} = csa(pp_row[0], pp_row[1], pp_row[2]);
    assign {c1, s1} = csa(pp_row[3], pp_row[4], pp_row[5]);
    assign {c2, s2} = csa(pp_row[6], pp_row[7], pp_row[8]);
    assign {d0, t0} = csa(s0, c0, s1);
    assign {d1, t1} = csa(c1, s2, c2);
    assign {e0, u0} = csa(t0, d0, t1);
    assign {f0, v0} = csa(u0, e0, d1);
    assign product  = v0 + f0;

    // Pipeline registers and round-robin pointer
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= 1'b0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_id    <= 1'b0;
            rr_ptr    <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= xfer_any;
                if (xfer_any) begin
                    s1_a  <= xfer1 ? req1_a : req0_a;
                    s1_b  <= xfer1 ? req1_b : req0_b;
                    s1_id <= xfer1;
                end
            end
            if (!stall) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_p  <= product;
                    out_id <= s1_id;
                end
            end
            if (RR && xfer_any) begin
                rr_ptr <= xfer0;
            end
        end
    end
endmodule

// File: tb/tb_mult16_share_arbiter.sv
// Directed bench for mult16_share_arbiter: reset, latency, corner products,
// contention (round-robin and fixed priority), backpressure, reset mid-flight, random stream.
module tb_mult16_share_arbiter;
    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        out_valid, out_id, out_ready, busy;
    logic [31:0] out_p;

    logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
    logic [15:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
    logic        f_out_valid, f_out_id, f_out_ready, f_busy;
    logic [31:0] f_out_p;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] exp_q [$];
    logic [15:0] ca [8];
    logic [15:0] cb [8];
    logic [31:0] cp [8];
    logic        xfer1;

    always #5 sys_clk = ~sys_clk;

    mult16_share_arbiter #(.RR_EN(1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_p(out_p), .out_id(out_id), .out_ready(out_ready),
        .busy(busy)
    );

    mult16_share_arbiter #(.RR_EN(0)) dut_fp (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req0_valid(f_req0_valid), .req0_a(f_req0_a), .req0_b(f_req0_b), .req0_ready(f_req0_ready),
        .req1_valid(f_req1_valid), .req1_a(f_req1_a), .req1_b(f_req1_b), .req1_ready(f_req1_ready),
        .out_valid(f_out_valid), .out_p(f_out_p), .out_id(f_out_id), .out_ready(f_out_ready),
        .busy(f_busy)
    );

    function automatic logic [31:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        return 32'(sa * sb);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard the handshakes of the current cycle, then advance one clock
    task automatic step();
        logic [32:0] e;
        #1;
        chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_p", out_p, e[31:0]);
                chk("sb_id", 32'(out_id), 32'(e[32]));
            end
        end
        if (req0_valid && req0_ready) exp_q.push_back({1'b0, mul_ref(req0_a, req0_b)});
        if (req1_valid && req1_ready) exp_q.push_back({1'b1, mul_ref(req1_a, req1_b)});
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        ca[0] = 16'h8000; cb[0] = 16'h8000; cp[0] = 32'h4000_0000;
        ca[1] = 16'h8000; cb[1] = 16'h7FFF; cp[1] = 32'hC000_8000;
        ca[2] = 16'h0000; cb[2] = 16'h1234; cp[2] = 32'h0000_0000;
        ca[3] = 16'h7FFF; cb[3] = 16'h7FFF; cp[3] = 32'h3FFF_0001;
        ca[4] = 16'hFFFF; cb[4] = 16'hFFFF; cp[4] = 32'h0000_0001;
        ca[5] = 16'h1234; cb[5] = 16'h5678; cp[5] = 32'h0626_0060;
        ca[6] = 16'hFFFE; cb[6] = 16'h7FFF; cp[6] = 32'hFFFF_0002;
        ca[7] = 16'h8000; cb[7] = 16'h0001; cp[7] = 32'hFFFF_8000;

        sys_rst = 1'b1; out_ready = 1'b1; xfer1 = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'hFFFE;
        req1_valid = 1'b1; req1_a = 16'h0000; req1_b = 16'h0000;
        f_req0_valid = 1'b0; f_req0_a = '0; f_req0_b = '0;
        f_req1_valid = 1'b0; f_req1_a = '0; f_req1_b = '0;
        f_out_ready = 1'b1;

        // Reset state, readys gated while reset is high
        @(posedge sys_clk);
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_p", out_p, 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);

        // Single op right after release: 3 * -2
        sys_rst = 1'b0; req1_valid = 1'b0;
        #1;
        chk("first_edge_ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        #1;
        chk("lat1_out_valid", 32'(out_valid), 32'd0);
        chk("lat1_busy", 32'(busy), 32'd1);
        step();
        chk("lat2_out_valid", 32'(out_valid), 32'd1);
        chk("single_p", out_p, 32'hFFFF_FFFA);
        chk("single_id", 32'(out_id), 32'd0);
        step();
        chk("single_done_valid", 32'(out_valid), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);
        chk("idle_p_hold", out_p, 32'hFFFF_FFFA);

        // Corner products, back-to-back at full rate
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                req0_valid = 1'b1; req0_a = ca[c]; req0_b = cb[c];
            end else begin
                req0_valid = 1'b0;
            end
            #1;
            if (c < 8) chk("corner_ready", 32'(req0_ready), 32'd1);
            step();
            if (c >= 1) begin
                chk("corner_valid", 32'(out_valid), 32'd1);
                chk($sformatf("corner_p%0d", c - 1), out_p, cp[c-1]);
            end
        end
        step();

        // Reset with S1 and S2 both full
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; out_ready = 1'b0;
        #1;
        chk("mf_ready_a", 32'(req0_ready), 32'd1);
        step();
        req0_a = 16'h0002; req0_b = 16'h0002;
        #1;
        chk("mf_ready_b", 32'(req0_ready), 32'd1);
        step();
        req0_a = 16'h0003; req0_b = 16'h0003;
        #1;
        chk("mf_full_valid", 32'(out_valid), 32'd1);
        chk("mf_full_busy", 32'(busy), 32'd1);
        chk("mf_full_ready", 32'(req0_ready), 32'd0);
        sys_rst = 1'b1;
        #1;
        chk("mf_rst_valid", 32'(out_valid), 32'd0);
        chk("mf_rst_busy", 32'(busy), 32'd0);
        chk("mf_rst_ready", 32'(req0_ready), 32'd0);
        exp_q.delete();
        step();
        sys_rst = 1'b0; req0_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mf_no_stale", 32'(out_valid), 32'd0);
        end

        // Contention: round-robin alternates from requester 0; fixed priority keeps 0
        for (int c = 0; c <= 6; c++) begin
            if (c < 6) begin
                req0_valid = 1'b1; req0_a = 16'h0002; req0_b = 16'h0003;
                req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'hFFFF;
                f_req0_valid = 1'b1; f_req0_a = 16'h0002; f_req0_b = 16'h0003;
                f_req1_valid = 1'b1; f_req1_a = 16'h0005; f_req1_b = 16'hFFFF;
            end else begin
                req0_valid = 1'b0; req1_valid = 1'b0;
                f_req0_valid = 1'b0; f_req1_valid = 1'b0;
            end
            #1;
            if (c < 6) begin
                chk("rr_ready0", 32'(req0_ready), 32'(c % 2 == 0));
                chk("rr_ready1", 32'(req1_ready), 32'(c % 2 == 1));
                chk("fp_ready0", 32'(f_req0_ready), 32'd1);
                chk("fp_ready1", 32'(f_req1_ready), 32'd0);
            end
            step();
            if (c >= 1) begin
                chk("rr_out_valid", 32'(out_valid), 32'd1);
                chk("rr_out_id", 32'(out_id), 32'((c - 1) % 2));
                chk("rr_out_p", out_p, ((c - 1) % 2 != 0) ? 32'hFFFF_FFFB : 32'h0000_0006);
                chk("fp_out_valid", 32'(f_out_valid), 32'd1);
                chk("fp_out_id", 32'(f_out_id), 32'd0);
                chk("fp_out_p", f_out_p, 32'h0000_0006);
            end
        end
        step();
        chk("fp_busy_idle", 32'(f_busy), 32'd0);

        // Backpressure: four ops, consumer stalls three cycles
        req0_valid = 1'b1; req0_a = 16'h0010; req0_b = 16'h0010;
        #1;
        chk("bp_ready_op0", 32'(req0_ready), 32'd1);
        step();
        req0_a = 16'h0100; req0_b = 16'h0100;
        #1;
        chk("bp_ready_op1", 32'(req0_ready), 32'd1);
        step();
        req0_a = 16'hFFF0; req0_b = 16'h0010;
        for (int c = 0; c < 3; c++) begin
            out_ready = 1'b0;
            #1;
            chk("bp_stall_ready", 32'(req0_ready), 32'd0);
            step();
            chk("bp_stall_valid", 32'(out_valid), 32'd1);
            chk("bp_stall_p", out_p, 32'h0000_0100);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(req0_ready), 32'd1);
        step();
        chk("bp_p1", out_p, 32'h0001_0000);
        req0_a = 16'h7FFF; req0_b = 16'h0002;
        #1;
        chk("bp_ready_op3", 32'(req0_ready), 32'd1);
        step();
        chk("bp_p2", out_p, 32'hFFFF_FF00);
        req0_valid = 1'b0;
        step();
        chk("bp_p3", out_p, 32'h0000_FFFE);
        step();
        chk("bp_drained_valid", 32'(out_valid), 32'd0);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Random operands with random consumer backpressure
        for (int i = 0; i < 300; i++) begin
            if (!req1_valid || xfer1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a = 16'($urandom);
                req1_b = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            xfer1 = req1_valid && req1_ready;
            step();
        end
        req1_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
